// File: rtl/riscv_sim_monitor.sv
`timescale 1ns/1ps
// riscv_sim_monitor: end-of-test monitor for the riscv_soc harness.
// Shadows a window of GPRs from the register-file write-back port, reports
// value changes, and decides done/pass/timeout for the finish logic.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for en; shadows track writes, no change events
// ST_RUN     | test running; cyc_cnt counts, change events, done/watchdog
// ST_DONE    | DONE_REG written nonzero; pass latched; shadows frozen
// ST_TIMEOUT | watchdog expired before done; pass=0; shadows frozen
module riscv_sim_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_WATCH      = 3,
  parameter int WATCH_BASE     = 27,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 32,
  parameter int IDX_W          = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      wb_we,
  input  logic [4:0]                wb_waddr,
  input  logic [XLEN-1:0]           wb_wdata,
  output logic [NUM_WATCH*XLEN-1:0] watch_data,
  output logic                      chg_vld,
  output logic [IDX_W-1:0]          chg_idx,
  output logic [XLEN-1:0]           chg_data,
  output logic [CNT_W-1:0]          cyc_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TIMEOUT} state_t;

  // Last RUN cycle before the watchdog fires; unused when the watchdog is off.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                           state_q, state_d;
  logic [NUM_WATCH-1:0][XLEN-1:0]   shadow_q;
  logic                             pass_sh_q;   // pass shadow == 1
  logic                             wr_ok;
  logic                             upd_en;
  logic                             win_hit;
  logic [IDX_W-1:0]                 win_idx;
  logic [XLEN-1:0]                  win_cur;
  logic                             done_hit;
  logic                             pass_wr;
  logic                             pass_next;
  logic                             wd_hit;
  logic                             run;

  // x0 writes never count for anything.
  assign wr_ok     = wb_we && (wb_waddr != 5'd0);
  assign run       = (state_q == ST_RUN);
  assign upd_en    = ((state_q == ST_IDLE) || run) && !clr;
  assign done_hit  = wr_ok && (wb_waddr == 5'(DONE_REG)) && (wb_wdata != '0);
  assign pass_wr   = wr_ok && (wb_waddr == 5'(PASS_REG));
  // When the done register doubles as the pass register, judge the data being written.
  assign pass_next = (DONE_REG == PASS_REG) ? (wb_wdata == XLEN'(1)) : pass_sh_q;
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && (cyc_cnt == TO_LAST);

  assign watch_data = shadow_q;
  assign busy       = run;

  // Window decode: which watched slot (if any) this write targets.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_cur = '0;
    for (int i = 0; i < NUM_WATCH; i++) begin
      if (wr_ok && (wb_waddr == 5'(WATCH_BASE + i))) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_cur = shadow_q[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clr beats everything, done beats the watchdog.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_d = ST_RUN;
        ST_RUN: begin
          if (done_hit)    state_d = ST_DONE;
          else if (wd_hit) state_d = ST_TIMEOUT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // RUN cycle counter: cleared on RUN entry, saturating, frozen elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cyc_cnt <= '0;
    else if (clr)                        cyc_cnt <= '0;
    else if ((state_q == ST_IDLE) && en) cyc_cnt <= '0;
    else if (run && (cyc_cnt != '1))     cyc_cnt <= cyc_cnt + 1'b1;
  end

  // Shadow copies of the watched window and the pass register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      pass_sh_q <= 1'b0;
    end else if (clr) begin
      shadow_q  <= '0;
      pass_sh_q <= 1'b0;
    end else if (upd_en) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (wr_ok && (wb_waddr == 5'(WATCH_BASE + i))) shadow_q[i] <= wb_wdata;
      end
      if (pass_wr) pass_sh_q <= (wb_wdata == XLEN'(1));
    end
  end

  // Change event: pulse only on a real value change during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_vld  <= 1'b0;
      chg_idx  <= '0;
      chg_data <= '0;
    end else if (clr) begin
      chg_vld  <= 1'b0;
      chg_idx  <= '0;
      chg_data <= '0;
    end else begin
      chg_vld <= run && win_hit && (wb_wdata != win_cur);
      if (run && win_hit && (wb_wdata != win_cur)) begin
        chg_idx  <= win_idx;
        chg_data <= wb_wdata;
      end
    end
  end

  // Sticky verdict flags, set on the RUN exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else if (clr) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else if (run) begin
      if (done_hit) begin
        done <= 1'b1;
        pass <= pass_next;
      end else if (wd_hit) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_sim_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for riscv_sim_monitor: the stimulus pushes expected change
// events and end-of-test verdicts; a negedge monitor pops and compares them.
module tb_riscv_sim_monitor;

  localparam int XLEN = 32;
  localparam int NW   = 3;
  localparam int CW   = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, clr, wb_we;
  logic [4:0]       wb_waddr;
  logic [XLEN-1:0]  wb_wdata;
  logic [NW*XLEN-1:0] watch_data;
  logic             chg_vld;
  logic [4:0]       chg_idx;
  logic [XLEN-1:0]  chg_data;
  logic [CW-1:0]    cyc_cnt;
  logic             busy, done, pass, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] chg_q[$];   // {idx, data}
  logic [63:0] end_q[$];   // {done, pass, timeout, cyc_cnt}
  logic        fin_q = 1'b0;

  riscv_sim_monitor #(
    .XLEN(XLEN), .NUM_WATCH(NW), .WATCH_BASE(27), .DONE_REG(26), .PASS_REG(27),
    .TIMEOUT_CYCLES(50), .CNT_W(CW), .IDX_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .watch_data(watch_data), .chg_vld(chg_vld), .chg_idx(chg_idx),
    .chg_data(chg_data), .cyc_cnt(cyc_cnt), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [XLEN-1:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    tick();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic start();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic exp_chg(input int idx, input int data);
    chg_q.push_back({32'(idx), 32'(data)});
  endtask

  task automatic exp_end(input bit d, input bit p, input bit t, input int cnt);
    end_q.push_back({29'd0, d, p, t, 32'(cnt)});
  endtask

  task automatic wait_cnt(input int target, input string nm);
    for (int i = 0; i < 200 && cyc_cnt != CW'(target); i++) tick();
    chk(nm, cyc_cnt, target);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"}, {chg_vld, busy, done, pass, timeout}, 5'b0);
    chk({nm, "_cnt"}, cyc_cnt, 0);
    chk({nm, "_watch"}, watch_data, 0);
  endtask

  // Monitor: compare every change pulse and every verdict against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (chg_vld) begin
        if (chg_q.size() == 0) chk("chg_unexpected", {chg_idx, chg_data}, 0);
        else chk("chg_event", {32'(chg_idx), chg_data}, chg_q.pop_front());
      end
      if ((done | timeout) && !fin_q) begin
        if (end_q.size() == 0) chk("end_unexpected", {done, pass, timeout}, 0);
        else chk("end_verdict", {29'd0, done, pass, timeout, cyc_cnt}, end_q.pop_front());
      end
      fin_q = done | timeout;
    end else begin
      fin_q = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    tick(); tick();
    chk_zero("reset");
    chk("reset_chg", {chg_idx, chg_data}, 0);
    rst_n = 1'b1;
    tick();

    // Run 1: change events, filtering, pass verdict.
    start();
    chk("run_busy", busy, 1);
    exp_chg(0, 5); wr(27, 5);
    exp_chg(1, 7); wr(28, 7);
    exp_chg(2, 9); wr(29, 9);
    tick();
    chk("watch_579", watch_data, {32'd9, 32'd7, 32'd5});
    wr(28, 7);
    wr(0, 123);
    wr(30, 55);
    tick();
    chk("watch_unchanged", watch_data, {32'd9, 32'd7, 32'd5});
    exp_chg(0, 1); wr(27, 1);
    wait_cnt(20, "wait_c20_a");
    exp_end(1, 1, 0, 21); wr(26, 1);
    chk("done_pass_busy", {busy, done, pass, timeout}, 4'b0110);
    wr(27, 77);
    tick();
    chk("done_frozen", watch_data, {32'd9, 32'd7, 32'd1});
    chk("done_cnt_frozen", cyc_cnt, 21);
    do_clr();
    chk_zero("clr1");

    // Run 2: pass shadow 3 then 0 -> fail verdict.
    start();
    exp_chg(0, 3); wr(27, 3);
    exp_chg(0, 0); wr(27, 0);
    wait_cnt(20, "wait_c20_b");
    exp_end(1, 0, 0, 21); wr(26, 1);
    chk("done_fail", {done, pass, timeout}, 3'b100);
    do_clr();

    // Run 3: watchdog expiry; later done writes and en are ignored.
    start();
    exp_end(0, 0, 1, 50);
    for (int i = 0; i < 200 && !timeout; i++) tick();
    chk("timeout_cnt", {timeout, cyc_cnt}, {1'b1, 32'd50});
    wr(26, 1);
    wr(27, 8);
    en = 1'b1; tick(); en = 1'b0;
    chk("timeout_sticky", {busy, done, pass, timeout}, 4'b0001);
    chk("timeout_frozen", {watch_data, cyc_cnt}, {96'd0, 32'd50});
    do_clr();

    // Run 4: IDLE pass write, zero done write ignored, done on the watchdog cycle.
    wr(27, 1);
    chk("idle_shadow", watch_data, {32'd0, 32'd0, 32'd1});
    start();
    wr(26, 0);
    chk("done_zero_ignored", {busy, done}, 2'b10);
    wait_cnt(49, "wait_c49");
    exp_end(1, 1, 0, 50); wr(26, 3);
    tick();
    chk("done_beats_wd", {done, pass, timeout}, 3'b110);
    do_clr();

    // Run 5: IDLE write without pulse, then clr with a concurrent write.
    wr(27, 4);
    chk("idle_shadow4", watch_data, {32'd0, 32'd0, 32'd4});
    start();
    exp_chg(1, 6); wr(28, 6);
    clr = 1'b1; wb_we = 1'b1; wb_waddr = 5'd27; wb_wdata = 32'd9;
    tick();
    clr = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    chk_zero("clr_write");
    chk("clr_chg", {chg_idx, chg_data}, 0);

    // Run 6: async reset in the middle of RUN.
    start();
    exp_chg(1, 2); wr(28, 2);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk_zero("after_rst");

    tick(); tick();
    chk("chg_q_drained", chg_q.size(), 0);
    chk("end_q_drained", end_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
